// File: rtl/ped_level_sched_if.sv
// Handshake/bus bundle for ped_level_sched.
//   slave  : sequencer side (drives o_*, samples i_*)
//   master : tree-search controller and arithmetic datapath side
// Groups: job request, multiply bank, accumulator, PED unit, result.
interface ped_level_sched_if #(
  parameter int unsigned WIDTH = 16
);
  // job request from the tree-search controller
  logic               i_job_valid;
  logic               o_job_ready;
  logic [1:0]         i_level;
  logic [WIDTH-1:0]   i_parent_pd;
  logic [WIDTH-1:0]   i_radius;
  logic [2*WIDTH-1:0] i_y;
  logic [8*WIDTH-1:0] i_r_row;
  logic [8*WIDTH-1:0] i_sym;
  // 4-lane complex multiply bank
  logic               o_mul_valid;
  logic [8*WIDTH-1:0] o_mul_a;
  logic [8*WIDTH-1:0] o_mul_b;
  logic               i_mul_valid;
  logic [8*WIDTH-1:0] i_mul_data;
  // 4-input complex accumulator
  logic               o_acc_valid;
  logic [8*WIDTH-1:0] o_acc_data;
  logic               i_acc_valid;
  logic [2*WIDTH-1:0] i_acc_data;
  // PED unit
  logic               o_ped_valid;
  logic [2*WIDTH-1:0] o_ped_a;
  logic [2*WIDTH-1:0] o_ped_b;
  logic               i_ped_valid;
  logic [2*WIDTH-1:0] i_ped_data;
  // result to the controller
  logic               o_res_valid;
  logic               i_res_ready;
  logic [WIDTH-1:0]   o_res_metric;
  logic               o_res_accept;
  logic               o_res_err;
  logic               o_busy;

  modport slave (
    input  i_job_valid, i_level, i_parent_pd, i_radius, i_y, i_r_row, i_sym,
    input  i_mul_valid, i_mul_data, i_acc_valid, i_acc_data,
    input  i_ped_valid, i_ped_data, i_res_ready,
    output o_job_ready, o_mul_valid, o_mul_a, o_mul_b, o_acc_valid, o_acc_data,
    output o_ped_valid, o_ped_a, o_ped_b,
    output o_res_valid, o_res_metric, o_res_accept, o_res_err, o_busy
  );

  modport master (
    output i_job_valid, i_level, i_parent_pd, i_radius, i_y, i_r_row, i_sym,
    output i_mul_valid, i_mul_data, i_acc_valid, i_acc_data,
    output i_ped_valid, i_ped_data, i_res_ready,
    input  o_job_ready, o_mul_valid, o_mul_a, o_mul_b, o_acc_valid, o_acc_data,
    input  o_ped_valid, o_ped_a, o_ped_b,
    input  o_res_valid, o_res_metric, o_res_accept, o_res_err, o_busy
  );
endinterface

// File: rtl/ped_level_sched.sv
// Sequencer for one sphere-decoder tree-level metric update: issues the job to
// the multiply bank, accumulator and PED unit in turn, adds the squared
// distance to the parent metric (saturating) and compares it with the radius.
// Ports:
//   i_clk   : clock, posedge
//   i_rst_n : asynchronous active-low reset
//   bus     : ped_level_sched_if.slave (job, mul, acc, ped and result groups)
// All outputs are registered.
module ped_level_sched #(
  parameter int unsigned INT_W   = 6,
  parameter int unsigned FRAC_W  = 10,
  parameter int unsigned WIDTH   = INT_W + FRAC_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  ped_level_sched_if.slave bus
);
  localparam int unsigned CW    = 2 * WIDTH;
  localparam int unsigned LW    = 8 * WIDTH;
  localparam int unsigned LANES = 4;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, ISSUE_MUL, WAIT_MUL, ISSUE_ACC, WAIT_ACC, ISSUE_PED, WAIT_PED, CMP, DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] wd_cnt_q;
  logic             wd_last;
  logic             in_wait;
  logic             job_take, mul_take, acc_take, ped_take, cmp_go, wd_expire;

  logic [WIDTH-1:0] parent_q, radius_q, inc_q;
  logic [CW-1:0]    y_q, sum_q;
  logic [LW-1:0]    mul_a_q, mul_b_q, acc_q;
  logic [LW-1:0]    sym_gated;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] metric_sat;

  logic             job_ready_q, busy_q, mul_v_q, acc_v_q, ped_v_q, res_v_q;
  logic [WIDTH-1:0] metric_q;
  logic             accept_q, err_q;

  // Only the real (low) half of the PED word carries the distance.
  logic unused_ped_hi;
  assign unused_ped_hi = ^bus.i_ped_data[CW-1:WIDTH];

  // Last cycle a WAIT state may still take its response.
  assign wd_last = (wd_cnt_q == CNT_W'(TIMEOUT - 1));
  assign in_wait = (state_q == WAIT_MUL) || (state_q == WAIT_ACC) || (state_q == WAIT_PED);

  // Next-state and per-cycle capture strobes.
  always_comb begin
    state_d   = state_q;
    job_take  = 1'b0;
    mul_take  = 1'b0;
    acc_take  = 1'b0;
    ped_take  = 1'b0;
    cmp_go    = 1'b0;
    wd_expire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_job_valid) begin
          job_take = 1'b1;
          state_d  = ISSUE_MUL;
        end
      end
      ISSUE_MUL: state_d = WAIT_MUL;
      WAIT_MUL: begin
        if (bus.i_mul_valid) begin
          mul_take = 1'b1;
          state_d  = ISSUE_ACC;
        end else if (wd_last) begin
          wd_expire = 1'b1;
          state_d   = DONE;
        end
      end
      ISSUE_ACC: state_d = WAIT_ACC;
      WAIT_ACC: begin
        if (bus.i_acc_valid) begin
          acc_take = 1'b1;
          state_d  = ISSUE_PED;
        end else if (wd_last) begin
          wd_expire = 1'b1;
          state_d   = DONE;
        end
      end
      ISSUE_PED: state_d = WAIT_PED;
      WAIT_PED: begin
        if (bus.i_ped_valid) begin
          ped_take = 1'b1;
          state_d  = CMP;
        end else if (wd_last) begin
          wd_expire = 1'b1;
          state_d   = DONE;
        end
      end
      CMP: begin
        cmp_go  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (bus.i_res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Lanes below the tree level contribute nothing: zero their symbol operand.
  always_comb begin
    sym_gated = bus.i_sym;
    for (int unsigned j = 0; j < LANES; j++) begin
      if (2'(j) < bus.i_level) sym_gated[CW*j +: CW] = '0;
    end
  end

  // Saturating metric update.
  assign sum_ext    = (WIDTH+1)'(parent_q) + (WIDTH+1)'(inc_q);
  assign metric_sat = sum_ext[WIDTH] ? '1 : sum_ext[WIDTH-1:0];

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Watchdog: cleared on every state change, counts while parked in a WAIT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                         wd_cnt_q <= '0;
    else if (in_wait && state_d == state_q) wd_cnt_q <= wd_cnt_q + CNT_W'(1);
    else                                  wd_cnt_q <= '0;
  end

  // Registered strobes/status, aligned with the state they belong to.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      job_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      mul_v_q     <= 1'b0;
      acc_v_q     <= 1'b0;
      ped_v_q     <= 1'b0;
      res_v_q     <= 1'b0;
    end else begin
      job_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      mul_v_q     <= (state_d == ISSUE_MUL);
      acc_v_q     <= (state_d == ISSUE_ACC);
      ped_v_q     <= (state_d == ISSUE_PED);
      res_v_q     <= (state_d == DONE);
    end
  end

  // Job capture and datapath response capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      parent_q <= '0;
      radius_q <= '0;
      y_q      <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      inc_q    <= '0;
    end else begin
      if (job_take) begin
        parent_q <= bus.i_parent_pd;
        radius_q <= bus.i_radius;
        y_q      <= bus.i_y;
        mul_a_q  <= bus.i_r_row;
        mul_b_q  <= sym_gated;
      end
      if (mul_take) acc_q <= bus.i_mul_data;
      if (acc_take) sum_q <= bus.i_acc_data;
      if (ped_take) inc_q <= bus.i_ped_data[WIDTH-1:0];
    end
  end

  // Result registers: written only when entering DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      metric_q <= '0;
      accept_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (cmp_go) begin
      metric_q <= metric_sat;
      accept_q <= (metric_sat <= radius_q);
      err_q    <= 1'b0;
    end else if (wd_expire) begin
      metric_q <= '1;
      accept_q <= 1'b0;
      err_q    <= 1'b1;
    end
  end

  assign bus.o_job_ready  = job_ready_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_mul_valid  = mul_v_q;
  assign bus.o_mul_a      = mul_a_q;
  assign bus.o_mul_b      = mul_b_q;
  assign bus.o_acc_valid  = acc_v_q;
  assign bus.o_acc_data   = acc_q;
  assign bus.o_ped_valid  = ped_v_q;
  assign bus.o_ped_a      = y_q;
  assign bus.o_ped_b      = sum_q;
  assign bus.o_res_valid  = res_v_q;
  assign bus.o_res_metric = metric_q;
  assign bus.o_res_accept = accept_q;
  assign bus.o_res_err    = err_q;
endmodule

// File: tb/tb_ped_level_sched.sv
// Scoreboard bench for ped_level_sched: stimulus pushes expected issues and
// results into queues; a negedge monitor pops and compares on every strobe.
module tb_ped_level_sched;
  localparam int unsigned W = 16;

  localparam logic [127:0] SA    = 128'h0400_0400_0300_0300_0200_0200_0100_0100;
  localparam logic [127:0] SB    = {4{32'h02D4_02D4}};
  localparam logic [127:0] RROW  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] PROD  = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [31:0]  SUM0  = 32'h0AAA_0555;
  localparam logic [31:0]  Y0    = 32'h0100_0200;

  logic clk;
  logic rst_n;

  ped_level_sched_if #(.WIDTH(W)) bus();

  ped_level_sched dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0]   level;
    logic [127:0] sym;
    logic [127:0] mulb;
    logic [15:0]  parent;
    logic [15:0]  radius;
    logic [15:0]  ped;
    int           al;
    int           hold;
    logic [15:0]  metric;
    logic         accept;
    logic         err;
    int           off;
  } vec_t;

  typedef struct {
    logic [15:0] metric;
    logic        accept;
    logic        err;
    int          cyc;
  } res_exp_t;

  logic [127:0] q_mul_a[$];
  logic [127:0] q_mul_b[$];
  logic [127:0] q_acc[$];
  logic [63:0]  q_ped[$];
  res_exp_t     q_res[$];

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;
  int mul_at = -1, acc_at = -1, ped_at = -1;
  int ml = 1, al = 1, pl = 2;
  logic [127:0] cur_prod;
  logic [31:0]  cur_sum, cur_ped;
  bit res_prev = 1'b0;

  logic [127:0] m_a, m_b, m_acc;
  logic [63:0]  m_ped;
  res_exp_t     m_res;
  vec_t         vecs[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    nvec++;
    nmis++;
    $display("FAIL %s: actual strobe seen, required none (cycle %0d)", nm, cyc);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_job_ready"}, bus.o_job_ready, 1);
    chk({tag, "_busy"}, bus.o_busy, 0);
    chk({tag, "_mul_valid"}, bus.o_mul_valid, 0);
    chk({tag, "_acc_valid"}, bus.o_acc_valid, 0);
    chk({tag, "_ped_valid"}, bus.o_ped_valid, 0);
    chk({tag, "_res_valid"}, bus.o_res_valid, 0);
    chk({tag, "_mul_a"}, bus.o_mul_a, 0);
    chk({tag, "_mul_b"}, bus.o_mul_b, 0);
    chk({tag, "_acc_data"}, bus.o_acc_data, 0);
    chk({tag, "_ped_a"}, bus.o_ped_a, 0);
    chk({tag, "_ped_b"}, bus.o_ped_b, 0);
    chk({tag, "_metric"}, bus.o_res_metric, 0);
    chk({tag, "_accept"}, bus.o_res_accept, 0);
    chk({tag, "_err"}, bus.o_res_err, 0);
  endtask

  function automatic vec_t mk(input logic [1:0] level, input logic [127:0] sym,
                              input logic [127:0] mulb, input logic [15:0] parent,
                              input logic [15:0] radius, input logic [15:0] ped,
                              input int a, input int hold, input logic [15:0] metric,
                              input logic accept, input logic err, input int off);
    vec_t v;
    v.level = level; v.sym = sym; v.mulb = mulb; v.parent = parent;
    v.radius = radius; v.ped = ped; v.al = a; v.hold = hold;
    v.metric = metric; v.accept = accept; v.err = err; v.off = off;
    return v;
  endfunction

  // Datapath responder: returns each response at its scheduled cycle.
  initial begin
    bus.i_mul_valid = 1'b0; bus.i_mul_data = '0;
    bus.i_acc_valid = 1'b0; bus.i_acc_data = '0;
    bus.i_ped_valid = 1'b0; bus.i_ped_data = '0;
    forever begin
      @(posedge clk); #1;
      bus.i_mul_valid = (cyc == mul_at);
      bus.i_mul_data  = (cyc == mul_at) ? cur_prod : '0;
      bus.i_acc_valid = (cyc == acc_at);
      bus.i_acc_data  = (cyc == acc_at) ? cur_sum : '0;
      bus.i_ped_valid = (cyc == ped_at);
      bus.i_ped_data  = (cyc == ped_at) ? cur_ped : '0;
    end
  end

  // Monitor: schedules responses and checks every issue strobe and result.
  always @(negedge clk) begin
    if (!rst_n) begin
      res_prev = 1'b0;
    end else begin
      if (bus.o_mul_valid) begin
        mul_at = cyc + ml;
        if (q_mul_a.size() == 0) unexpected("mul_issue");
        else begin
          m_a = q_mul_a.pop_front();
          m_b = q_mul_b.pop_front();
          chk("mul_a", bus.o_mul_a, m_a);
          chk("mul_b", bus.o_mul_b, m_b);
        end
      end
      if (bus.o_acc_valid) begin
        acc_at = cyc + al;
        if (q_acc.size() == 0) unexpected("acc_issue");
        else begin
          m_acc = q_acc.pop_front();
          chk("acc_data", bus.o_acc_data, m_acc);
        end
      end
      if (bus.o_ped_valid) begin
        ped_at = cyc + pl;
        if (q_ped.size() == 0) unexpected("ped_issue");
        else begin
          m_ped = q_ped.pop_front();
          chk("ped_a", bus.o_ped_a, m_ped[63:32]);
          chk("ped_b", bus.o_ped_b, m_ped[31:0]);
        end
      end
      if (bus.o_res_valid && !res_prev) begin
        if (q_res.size() == 0) unexpected("res_valid");
        else begin
          m_res = q_res.pop_front();
          chk("res_metric", bus.o_res_metric, m_res.metric);
          chk("res_accept", bus.o_res_accept, m_res.accept);
          chk("res_err", bus.o_res_err, m_res.err);
          chk("res_cycle", 128'(cyc), 128'(m_res.cyc));
        end
      end
      res_prev = bus.o_res_valid;
    end
  end

  // Drive one job; returns at #1 after the first IDLE edge following completion.
  task automatic run_job(input vec_t v, input int idx);
    int t0;
    int n;
    res_exp_t r;
    ml = 1; al = v.al; pl = 2;
    cur_prod = PROD ^ 128'(idx);
    cur_sum  = SUM0 + 32'(idx);
    cur_ped  = {16'hA5A5, v.ped};
    bus.i_level     = v.level;
    bus.i_parent_pd = v.parent;
    bus.i_radius    = v.radius;
    bus.i_y         = Y0 + 32'(idx);
    bus.i_r_row     = RROW ^ 128'(idx);
    bus.i_sym       = v.sym;
    t0 = cyc;
    q_mul_a.push_back(RROW ^ 128'(idx));
    q_mul_b.push_back(v.mulb);
    q_acc.push_back(cur_prod);
    if (!v.err) q_ped.push_back({Y0 + 32'(idx), cur_sum});
    r.metric = v.metric; r.accept = v.accept; r.err = v.err; r.cyc = t0 + v.off;
    q_res.push_back(r);
    bus.i_job_valid = 1'b1;
    @(negedge clk);
    chk("job_ready_idle", bus.o_job_ready, 1);
    chk("res_valid_idle", bus.o_res_valid, 0);
    @(posedge clk); #1;
    bus.i_job_valid = 1'b0;
    bus.i_res_ready = (v.hold == 0);
    @(negedge clk);
    chk("busy", bus.o_busy, 1);
    chk("job_ready_busy", bus.o_job_ready, 0);
    n = 0;
    while (!bus.o_res_valid && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("res_wait", bus.o_res_valid, 1);
    for (int h = 0; h < v.hold; h++) begin
      chk("hold_valid", bus.o_res_valid, 1);
      chk("hold_metric", bus.o_res_metric, v.metric);
      chk("hold_accept", bus.o_res_accept, v.accept);
      chk("hold_job_ready", bus.o_job_ready, 0);
      if (h < v.hold - 1) begin
        @(posedge clk); #1;
        bus.i_job_valid = (h % 2 == 0);
        bus.i_parent_pd = 16'h1234;
        bus.i_level     = 2'd3;
        @(negedge clk);
      end
    end
    if (v.hold > 0) begin
      @(posedge clk); #1;
      bus.i_job_valid = 1'b0;
      bus.i_res_ready = 1'b1;
      @(negedge clk);
      chk("ready_cycle_valid", bus.o_res_valid, 1);
      chk("ready_cycle_metric", bus.o_res_metric, v.metric);
    end
    @(posedge clk); #1;
    bus.i_res_ready = 1'b0;
  endtask

  initial begin
    int t0;
    rst_n = 1'b0;
    bus.i_job_valid = 1'b0; bus.i_res_ready = 1'b0;
    bus.i_level = '0; bus.i_parent_pd = '0; bus.i_radius = '0;
    bus.i_y = '0; bus.i_r_row = '0; bus.i_sym = '0;

    vecs[0] = mk(2'd3, SA, 128'h0400_0400_0000_0000_0000_0000_0000_0000,
                 16'h0000, 16'h0800, 16'h0300, 1, 0, 16'h0300, 1'b1, 1'b0, 9);
    vecs[1] = mk(2'd2, SB, 128'h02D4_02D4_02D4_02D4_0000_0000_0000_0000,
                 16'h0100, 16'h0100, 16'h0050, 1, 0, 16'h0150, 1'b0, 1'b0, 9);
    vecs[2] = mk(2'd0, SA, SA, 16'hFF00, 16'hFFFE, 16'h0200, 1, 0, 16'hFFFF, 1'b0, 1'b0, 9);
    vecs[3] = mk(2'd1, SA, 128'h0400_0400_0300_0300_0200_0200_0000_0000,
                 16'hFF00, 16'hFFFF, 16'h0200, 1, 0, 16'hFFFF, 1'b1, 1'b0, 9);
    vecs[4] = mk(2'd0, SB, SB, 16'h0200, 16'h0400, 16'h0200, 1, 5, 16'h0400, 1'b1, 1'b0, 9);
    vecs[5] = mk(2'd3, SA, 128'h0400_0400_0000_0000_0000_0000_0000_0000,
                 16'h0010, 16'h0FFF, 16'h0020, 16, 0, 16'hFFFF, 1'b0, 1'b1, 19);
    vecs[6] = mk(2'd3, SA, 128'h0400_0400_0000_0000_0000_0000_0000_0000,
                 16'h0010, 16'h0030, 16'h0020, 15, 0, 16'h0030, 1'b1, 1'b0, 23);

    repeat (2) @(negedge clk);
    chk_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_job(vecs[i], i);

    // Reset while waiting for the PED unit; its late response must be ignored.
    ml = 1; al = 1; pl = 10;
    cur_prod = PROD; cur_sum = SUM0; cur_ped = {16'hA5A5, 16'h0040};
    bus.i_level = 2'd0; bus.i_parent_pd = 16'h0100; bus.i_radius = 16'h0800;
    bus.i_y = Y0; bus.i_r_row = RROW; bus.i_sym = SA;
    q_mul_a.push_back(RROW);
    q_mul_b.push_back(SA);
    q_acc.push_back(PROD);
    q_ped.push_back({Y0, SUM0});
    t0 = cyc;
    bus.i_job_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_job_valid = 1'b0;
    while (cyc < t0 + 8) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    while (cyc < t0 + 18) begin
      @(negedge clk);
      chk("post_reset_job_ready", bus.o_job_ready, 1);
      chk("post_reset_busy", bus.o_busy, 0);
      chk("post_reset_res_valid", bus.o_res_valid, 0);
      chk("post_reset_metric", bus.o_res_metric, 0);
    end

    repeat (3) @(negedge clk);
    chk("q_mul_empty", 128'(q_mul_a.size()), 0);
    chk("q_acc_empty", 128'(q_acc.size()), 0);
    chk("q_ped_empty", 128'(q_ped.size()), 0);
    chk("q_res_empty", 128'(q_res.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
